// File: rtl/audio_mix_scheduler_pkg.sv
// Shared types and helpers for the audio mix scheduler and its I2S serializer.
package audio_pkg;

  localparam int unsigned I2S_FRAME_BITS = 32;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REQ,
    DONE
  } mix_state_t;

  // Clamp a sign-extended accumulator to the signed range of a width-bit sample.
  function automatic logic signed [31:0] sat_sample(input logic signed [31:0] acc,
                                                     input int unsigned width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (acc > hi) begin
      return hi;
    end
    if (acc < lo) begin
      return lo;
    end
    return acc;
  endfunction

endpackage

// File: rtl/audio_mix_scheduler_i2s_tx_shifter.sv
// Frame shift register driving the I2S data line, MSB first.
module i2s_tx_shifter
  import audio_pkg::*;
#(
  parameter int unsigned FRAME_BITS = I2S_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_strobe,
  input  logic                  shift_strobe,
  input  logic [FRAME_BITS-1:0] load_data,
  output logic                  i2s_data
);

  logic [FRAME_BITS-1:0] shreg_q;
  logic [FRAME_BITS-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_strobe) begin
      shreg_d = load_data;
    end else if (shift_strobe) begin
      shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign i2s_data = shreg_q[FRAME_BITS-1];

endmodule

// File: rtl/audio_mix_scheduler.sv
// Polls enabled sound sources once per sample period, sums them with saturation
// and hands the held stereo mix to the I2S serializer.
module audio_mix_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned NUM_SOURCES    = 4,
  parameter int unsigned SAMPLE_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                audio_clk,
  input  logic                                i2s_data_load_strobe,
  input  logic                                i2s_data_shift_strobe,
  input  logic [NUM_SOURCES-1:0]              src_enable,
  output logic [NUM_SOURCES-1:0]              src_req,
  input  logic [NUM_SOURCES-1:0]              src_ack,
  input  logic [NUM_SOURCES*SAMPLE_WIDTH-1:0] src_left,
  input  logic [NUM_SOURCES*SAMPLE_WIDTH-1:0] src_right,
  output logic [SAMPLE_WIDTH-1:0]             mix_left,
  output logic [SAMPLE_WIDTH-1:0]             mix_right,
  output logic                                i2s_data,
  output logic                                busy,
  output logic                                src_timeout,
  output logic                                overrun
);

  localparam int unsigned ACC_W = SAMPLE_WIDTH + $clog2(NUM_SOURCES) + 1;
  localparam int unsigned IDX_W = $clog2(NUM_SOURCES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  mix_state_t                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_SOURCES-1:0]    en_q, en_d;
  logic signed [ACC_W-1:0]   acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0]   acc_r_q, acc_r_d;
  logic [NUM_SOURCES-1:0]    req_q, req_d;
  logic [TO_W-1:0]           cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0]   mix_l_q, mix_l_d;
  logic [SAMPLE_WIDTH-1:0]   mix_r_q, mix_r_d;
  logic                      timeout_q, timeout_d;
  logic                      overrun_q, overrun_d;

  logic                      cur_en;
  logic                      cur_ack;
  logic signed [SAMPLE_WIDTH-1:0] cur_l;
  logic signed [SAMPLE_WIDTH-1:0] cur_r;

  always_comb begin
    cur_en  = 1'b0;
    cur_ack = 1'b0;
    cur_l   = '0;
    cur_r   = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_en  = en_q[i];
        cur_ack = src_ack[i];
        cur_l   = src_left[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        cur_r   = src_right[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    en_d      = en_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    mix_l_d   = mix_l_q;
    mix_r_d   = mix_r_q;
    timeout_d = 1'b0;
    overrun_d = 1'b0;

    // A new sample period preempts any scan in flight; the partial sum is discarded.
    if (audio_clk && (state_q != IDLE)) begin
      overrun_d = 1'b1;
      req_d     = '0;
      en_d      = src_enable;
      acc_l_d   = '0;
      acc_r_d   = '0;
      idx_d     = '0;
      cnt_d     = '0;
      state_d   = SCAN;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (audio_clk) begin
            en_d    = src_enable;
            acc_l_d = '0;
            acc_r_d = '0;
            idx_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (idx_q == IDX_W'(NUM_SOURCES)) begin
            state_d = DONE;
          end else if (cur_en) begin
            req_d   = NUM_SOURCES'(1) << idx_q;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        REQ: begin
          if (cur_ack) begin
            acc_l_d = acc_l_q + {{(ACC_W-SAMPLE_WIDTH){cur_l[SAMPLE_WIDTH-1]}}, cur_l};
            acc_r_d = acc_r_q + {{(ACC_W-SAMPLE_WIDTH){cur_r[SAMPLE_WIDTH-1]}}, cur_r};
            req_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            state_d = SCAN;
          end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            req_d     = '0;
            idx_d     = idx_q + IDX_W'(1);
            state_d   = SCAN;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        DONE: begin
          mix_l_d = SAMPLE_WIDTH'(sat_sample({{(32-ACC_W){acc_l_q[ACC_W-1]}}, acc_l_q},
                                             SAMPLE_WIDTH));
          mix_r_d = SAMPLE_WIDTH'(sat_sample({{(32-ACC_W){acc_r_q[ACC_W-1]}}, acc_r_q},
                                             SAMPLE_WIDTH));
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      en_q      <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      req_q     <= '0;
      cnt_q     <= '0;
      mix_l_q   <= '0;
      mix_r_q   <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      en_q      <= en_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      mix_l_q   <= mix_l_d;
      mix_r_q   <= mix_r_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign src_req     = req_q;
  assign mix_left    = mix_l_q;
  assign mix_right   = mix_r_q;
  assign busy        = (state_q != IDLE);
  assign src_timeout = timeout_q;
  assign overrun     = overrun_q;

  i2s_tx_shifter #(
    .FRAME_BITS(2 * SAMPLE_WIDTH)
  ) u_i2s_tx_shifter (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_strobe  (i2s_data_load_strobe),
    .shift_strobe (i2s_data_shift_strobe),
    .load_data    ({mix_l_q, mix_r_q}),
    .i2s_data     (i2s_data)
  );

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Scoreboard bench for audio_mix_scheduler: a reference model predicts mix, scan length
// and timeout count per scan; a monitor checks them whenever a scan completes.
module tb_audio_mix_scheduler;
  import audio_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 64;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           audio_clk = 1'b0;
  logic           ld = 1'b0;
  logic           sh = 1'b0;
  logic [N-1:0]   src_enable = '0;
  logic [N-1:0]   src_req;
  logic [N-1:0]   src_ack = '0;
  logic [N*W-1:0] src_left = '0;
  logic [N*W-1:0] src_right = '0;
  logic [W-1:0]   mix_left, mix_right;
  logic           i2s_data, busy, src_timeout, overrun;

  int cmp_n = 0;
  int fail_n = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
    int          tmo;
  } exp_t;
  exp_t sbq[$];

  int          dly[N];
  int          rc[N];
  sample_t     sl[N];
  sample_t     sr[N];
  logic        garbage = 1'b1;
  logic [15:0] mdl_l = '0;
  logic [15:0] mdl_r = '0;

  audio_mix_scheduler #(
    .NUM_SOURCES   (N),
    .SAMPLE_WIDTH  (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .audio_clk            (audio_clk),
    .i2s_data_load_strobe (ld),
    .i2s_data_shift_strobe(sh),
    .src_enable           (src_enable),
    .src_req              (src_req),
    .src_ack              (src_ack),
    .src_left             (src_left),
    .src_right            (src_right),
    .mix_left             (mix_left),
    .mix_right            (mix_right),
    .i2s_data             (i2s_data),
    .busy                 (busy),
    .src_timeout          (src_timeout),
    .overrun              (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each enabled source contributes if it answers within the timeout window.
  task automatic push_expected();
    exp_t e;
    int suml = 0;
    int sumr = 0;
    int cyc = 2;
    int tmo = 0;
    for (int i = 0; i < N; i++) begin
      if (src_enable[i]) begin
        if (dly[i] < int'(TO)) begin
          suml += sl[i];
          sumr += sr[i];
          cyc  += dly[i] + 2;
        end else begin
          cyc += int'(TO) + 1;
          tmo++;
        end
      end else begin
        cyc += 1;
      end
    end
    if (suml > 32767) suml = 32767;
    if (suml < -32768) suml = -32768;
    if (sumr > 32767) sumr = 32767;
    if (sumr < -32768) sumr = -32768;
    e.l = 16'(suml);
    e.r = 16'(sumr);
    e.cyc = cyc;
    e.tmo = tmo;
    mdl_l = e.l;
    mdl_r = e.r;
    sbq.push_back(e);
  endtask

  task automatic set_cfg(input logic [N-1:0] en);
    src_enable = en;
    for (int i = 0; i < N; i++) begin
      src_left[i*W +: W]  = sl[i];
      src_right[i*W +: W] = sr[i];
    end
  endtask

  task automatic pulse_audio();
    @(negedge clk);
    audio_clk = 1'b1;
    @(negedge clk);
    audio_clk = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("scan_finishes", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_req(input int i);
    int n = 0;
    while (!src_req[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("req%0d_rises", i), 32'(src_req[i]), 32'd1);
  endtask

  task automatic run_scan(input logic [N-1:0] en);
    set_cfg(en);
    push_expected();
    pulse_audio();
    wait_idle();
  endtask

  // Source responder: acknowledges dly[i] cycles after its request is seen.
  initial begin
    for (int i = 0; i < N; i++) rc[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (src_req[i]) begin
          src_ack[i] = (rc[i] >= dly[i]);
          rc[i]++;
        end else begin
          rc[i] = 0;
          src_ack[i] = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  // Monitor: measures each completed scan and compares it with the scoreboard head.
  initial begin
    int   bc = 0;
    int   tc = 0;
    logic pb = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bc = 0;
        tc = 0;
        pb = 1'b0;
      end else begin
        if (overrun) begin
          bc = 0;
          tc = 0;
        end
        if (busy) bc++;
        if (src_timeout) tc++;
        if (pb && !busy) begin
          chk("scoreboard_has_entry", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("mix_left", 32'(mix_left), 32'(e.l));
            chk("mix_right", 32'(mix_right), 32'(e.r));
            chk("scan_cycles", 32'(bc), 32'(e.cyc));
            chk("timeouts", 32'(tc), 32'(e.tmo));
          end
          bc = 0;
          tc = 0;
        end
        pb = busy;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] frame;
    logic [15:0] pl, pr;
    int          n;
    int          x;

    for (int i = 0; i < N; i++) begin
      dly[i] = 0;
      sl[i]  = '0;
      sr[i]  = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_src_req", 32'(src_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mix_left", 32'(mix_left), 32'd0);
    chk("rst_mix_right", 32'(mix_right), 32'd0);
    chk("rst_i2s_data", 32'(i2s_data), 32'd0);
    chk("rst_timeout", 32'(src_timeout), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Two sources, plain sum
    for (int i = 0; i < N; i++) dly[i] = 1;
    sl[0] = 16'h1000; sl[2] = 16'h0800; sr[0] = 16'hFF00; sr[2] = 16'h0010;
    run_scan(4'b0101);
    chk("t1_left", 32'(mix_left), 32'h1800);
    chk("t1_right", 32'(mix_right), 32'hFF10);

    // Saturation in both directions
    sl[0] = 16'h7000; sl[1] = 16'h7000; sr[0] = 16'h8000; sr[1] = 16'hF000;
    run_scan(4'b0011);
    chk("t2_left_sat", 32'(mix_left), 32'h7FFF);
    chk("t2_right_sat", 32'(mix_right), 32'h8000);

    // All disabled, then all enabled with immediate acks
    run_scan(4'b0000);
    for (int i = 0; i < N; i++) begin
      dly[i] = 0;
      sl[i]  = sample_t'(16'h0100 * (i + 1));
      sr[i]  = sample_t'(-16'sd3 * i);
    end
    run_scan(4'b1111);

    // Source 1 never answers
    sl[0] = 16'h0123; sr[0] = 16'hFEDC;
    dly[0] = 0; dly[1] = 255;
    set_cfg(4'b0011);
    push_expected();
    pulse_audio();
    wait_req(1);
    n = 0;
    while (!src_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t3_timeout_latency", 32'(n), 32'd64);
    chk("t3_req1_dropped", 32'(src_req[1]), 32'd0);
    wait_idle();

    // Ack on the last possible cycle versus one cycle too late
    dly[1] = 0; dly[0] = 63; sl[0] = 16'h0042; sr[0] = 16'h0024;
    run_scan(4'b0001);
    dly[0] = 64;
    run_scan(4'b0001);

    // Overrun while waiting on source 0
    pl = mdl_l; pr = mdl_r;
    dly[0] = 10; dly[1] = 0;
    sl[0] = 16'h0300; sl[1] = 16'h0030; sr[0] = 16'h0003; sr[1] = 16'hFFFF;
    set_cfg(4'b0011);
    pulse_audio();
    wait_req(0);
    repeat (3) @(negedge clk);
    push_expected();
    audio_clk = 1'b1;
    @(negedge clk);
    audio_clk = 1'b0;
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_req_low", 32'(src_req), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_old_left", 32'(mix_left), 32'(pl));
    chk("t4_old_right", 32'(mix_right), 32'(pr));
    @(negedge clk);
    chk("t4_restart_idx0", 32'(src_req), 32'd1);
    wait_idle();

    // Serializer
    dly[0] = 0; sl[0] = 16'hA5A5; sr[0] = 16'h5A5A;
    run_scan(4'b0001);
    frame = {mdl_l, mdl_r};
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    chk("ser_bit0", 32'(i2s_data), 32'(frame[31]));
    for (int k = 1; k < 32; k++) begin
      sh = 1'b1;
      @(negedge clk);
      sh = 1'b0;
      chk($sformatf("ser_bit%0d", k), 32'(i2s_data), 32'(frame[31-k]));
    end
    sh = 1'b1;
    @(negedge clk);
    sh = 1'b0;
    chk("ser_zero_fill", 32'(i2s_data), 32'd0);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    sh = 1'b1;
    repeat (3) @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    sh = 1'b0;
    chk("ser_load_wins", 32'(i2s_data), 32'(frame[31]));
    sh = 1'b1;
    @(negedge clk);
    sh = 1'b0;
    chk("ser_after_load_wins", 32'(i2s_data), 32'(frame[30]));

    // Asynchronous reset mid-request
    dly[0] = 20; dly[1] = 0; sl[0] = 16'h1111; sl[1] = 16'h2222;
    set_cfg(4'b0011);
    pulse_audio();
    wait_req(0);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_req", 32'(src_req), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_left", 32'(mix_left), 32'd0);
    chk("t6_right", 32'(mix_right), 32'd0);
    mdl_l = '0;
    mdl_r = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    dly[0] = 0;
    run_scan(4'b0011);

    // Randomized scans
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        sl[i] = sample_t'($urandom);
        sr[i] = sample_t'($urandom);
        x = int'($urandom_range(0, 9));
        if (x < 7) dly[i] = int'($urandom_range(0, 4));
        else if (x == 7) dly[i] = 255;
        else if (x == 8) dly[i] = 63;
        else dly[i] = 64;
      end
      run_scan(N'($urandom));
    end

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
